y86_run_ctrl: RTL and testbench

Parametrised run/status controller for the sequential Y86-64 core. It replaces the bare free-running PC register with:
- an architectural PC register with reset and start;
- a Y86 status register (AOK/HLT/ADR/INS);
- a commit gate that suppresses register-file and RAM writes on faulting or halting instructions;
- single-step mode, an optional watchdog, and saturating cycle/instruction counters.

It sits between fetch/pc_update (consumes newpc and fault signals) and the register file/RAM (drives commit).

---
 rtl/y86_pkg.sv | 36 +++
 rtl/sat_counter.sv | 15 +
 rtl/y86_run_ctrl.sv | 82 ++++++++
 tb/tb_y86_run_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, instruction codes and run-state encoding.
package y86_pkg;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [1:0] RS_IDLE    = 2'd0;
  localparam logic [1:0] RS_RUN     = 2'd1;
  localparam logic [1:0] RS_STEP    = 2'd2;
  localparam logic [1:0] RS_STOPPED = 2'd3;
  typedef enum logic [1:0] {
    IDLE    = RS_IDLE,
    RUN     = RS_RUN,
    STEP    = RS_STEP,
    STOPPED = RS_STOPPED
  } run_state_t;
  // Memory faults outrank decode faults, which outrank halt; AOK means no fault.
  function automatic logic [2:0] fault_code(input logic imem_err, input logic dmem_err,
                                            input logic valid, input logic [3:0] icode);
    return (imem_err || dmem_err) ? STAT_ADR :
           !valid                 ? STAT_INS :
           (icode == IHALT)       ? STAT_HLT : STAT_AOK;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/y86_run_ctrl.sv
// y86_run_ctrl: PC, status, commit gating, single-step, watchdog and counters
// for the sequential Y86-64 core.
module y86_run_ctrl
  import y86_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                CNT_W      = 32,
  parameter int                MAX_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              step_mode,
  input  logic              step,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] newpc,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stat,
  output logic              commit,
  output logic              running,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  run_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        stat_q, stat_d;
  logic              timeout_q, timeout_d;
  logic              exec, fault, wd_fire;
  logic [2:0]        code;
  assign running = state_q == RUN || state_q == STEP;
  assign exec    = state_q == RUN || (state_q == STEP && step);
  assign code    = fault_code(imem_error, dmem_error, instr_valid, icode);
  assign fault   = exec && code != STAT_AOK;
  assign commit  = exec && !fault && !clear;
  // The watchdog fires on the last permitted cycle so that cycle still counts.
  assign wd_fire = MAX_CYCLES != 0 && running && cycle_cnt == WD_LAST;
  always_comb begin
    state_d   = clear                     ? IDLE :
                (state_q == IDLE && start) ? (step_mode ? STEP : RUN) :
                running                   ? ((fault || wd_fire) ? STOPPED : (step_mode ? STEP : RUN)) :
                state_q;
    pc_d      = clear ? RESET_PC : commit ? newpc : pc_q;
    stat_d    = clear ? STAT_AOK : fault ? code : stat_q;
    timeout_d = clear ? 1'b0 : (wd_fire || timeout_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      timeout_q <= timeout_d;
    end
  assign pc      = pc_q;
  assign stat    = stat_q;
  assign timeout = timeout_q;
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (running),
    .q     (cycle_cnt)
  );
  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (commit),
    .q     (instr_cnt)
  );
endmodule

// File: tb/tb_y86_run_ctrl.sv
// tb_y86_run_ctrl: directed scoreboard bench for y86_run_ctrl with an 8-cycle watchdog.
module tb_y86_run_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, clear, step_mode, step, instr_valid, imem_error, dmem_error;
  logic [3:0]  icode;
  logic [63:0] newpc, pc;
  logic [2:0]  stat;
  logic        commit, running, timeout;
  logic [31:0] cycle_cnt, instr_cnt;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          wd_n     = 0;

  localparam int S_PC = 0, S_STAT = 1, S_COMMIT = 2, S_RUN = 3, S_TMO = 4, S_CYC = 5, S_INS = 6, S_WDN = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  assign newpc = pc + 64'd10;

  y86_run_ctrl #(.ADDR_W(64), .RESET_PC(64'd0), .CNT_W(32), .MAX_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .step_mode   (step_mode),
    .step        (step),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_error  (dmem_error),
    .newpc       (newpc),
    .pc          (pc),
    .stat        (stat),
    .commit      (commit),
    .running     (running),
    .timeout     (timeout),
    .cycle_cnt   (cycle_cnt),
    .instr_cnt   (instr_cnt)
  );

  function automatic logic [63:0] obs(int sel);
    case (sel)
      S_PC:     return pc;
      S_STAT:   return {61'd0, stat};
      S_COMMIT: return {63'd0, commit};
      S_RUN:    return {63'd0, running};
      S_TMO:    return {63'd0, timeout};
      S_CYC:    return {32'd0, cycle_cnt};
      S_INS:    return {32'd0, instr_cnt};
      default:  return 64'(wd_n);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] e);
    sb.push_back('{tag, sel, e});
  endtask

  task automatic drain();
    exp_t x;
    logic [63:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.sel);
      n_checks++;
      assert (o === x.exp) else begin
        n_fails++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; start = 0; clear = 0; step_mode = 0; step = 0;
    icode = 4'h6; instr_valid = 1; imem_error = 0; dmem_error = 0;
    #12;
    push("rst_pc", S_PC, 0); push("rst_stat", S_STAT, 1); push("rst_commit", S_COMMIT, 0);
    push("rst_running", S_RUN, 0); push("rst_timeout", S_TMO, 0);
    push("rst_cycle", S_CYC, 0); push("rst_instr", S_INS, 0);
    drain();
    rst_n = 1;
    start = 1; cyc(); start = 0;
    push("run_running", S_RUN, 1); drain();
    for (int i = 0; i < 5; i++) begin
      push("run_commit", S_COMMIT, 1); #1 drain(); cyc();
    end
    push("run_pc", S_PC, 50); push("run_instr", S_INS, 5); push("run_cycle", S_CYC, 5);
    push("run_stat", S_STAT, 1); drain();
    clear = 1; push("clear_no_commit", S_COMMIT, 0); #1 drain(); cyc(); clear = 0;
    push("clear_running", S_RUN, 0); push("clear_pc", S_PC, 0); push("clear_instr", S_INS, 0); drain();
    // halt at pc 0x28
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    icode = 4'h0; push("halt_commit", S_COMMIT, 0); #1 drain(); cyc(); icode = 4'h6;
    push("halt_stat", S_STAT, 2); push("halt_running", S_RUN, 0);
    push("halt_pc", S_PC, 64'h28); push("halt_instr", S_INS, 4); drain();
    cyc();
    push("stopped_pc", S_PC, 64'h28); push("stopped_commit", S_COMMIT, 0); drain();
    // fault priority
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    imem_error = 1; instr_valid = 0;
    push("adr_commit", S_COMMIT, 0); #1 drain(); cyc();
    imem_error = 0; instr_valid = 1;
    push("adr_stat", S_STAT, 3); push("adr_pc", S_PC, 0); push("adr_running", S_RUN, 0); drain();
    clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    instr_valid = 0; cyc(); instr_valid = 1;
    push("ins_stat", S_STAT, 4); drain();
    // single step
    clear = 1; cyc(); clear = 0;
    step_mode = 1; start = 1; cyc(); start = 0;
    push("step_running", S_RUN, 1); push("step_idle_commit", S_COMMIT, 0); drain();
    repeat (4) cyc();
    step = 1; push("step_commit", S_COMMIT, 1); #1 drain(); cyc(); cyc(); step = 0;
    push("step_pc", S_PC, 20); push("step_instr", S_INS, 2); push("step_cycle", S_CYC, 6);
    push("step_running2", S_RUN, 1); drain();
    // watchdog
    step_mode = 0; clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    wd_n = 0;
    while (running && wd_n < 20) begin
      cyc(); wd_n++;
    end
    push("wd_run_cycles", S_WDN, 8); push("wd_timeout", S_TMO, 1); push("wd_stat", S_STAT, 1);
    push("wd_instr", S_INS, 8); push("wd_cycle", S_CYC, 8); push("wd_pc", S_PC, 80);
    push("wd_running", S_RUN, 0); drain();
    // clear beats start while stopped
    clear = 1; start = 1; cyc(); clear = 0; start = 0;
    push("cs_running", S_RUN, 0); push("cs_pc", S_PC, 0); push("cs_cycle", S_CYC, 0);
    push("cs_instr", S_INS, 0); push("cs_timeout", S_TMO, 0); push("cs_stat", S_STAT, 1); drain();
    // async reset mid-run
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    push("pre_areset_pc", S_PC, 20); drain();
    #2 rst_n = 0; #1;
    push("areset_pc", S_PC, 0); push("areset_running", S_RUN, 0); push("areset_cycle", S_CYC, 0);
    push("areset_instr", S_INS, 0); push("areset_commit", S_COMMIT, 0); drain();
    rst_n = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
